// File: rtl/seg7_reader_if.sv
// Bundles the segment readback bus: the sampled segment lines and error clear going in,
// the decoded digit, status pulses, error count and debug state coming out.
interface seg7_reader_if;
  logic [6:0] seg_n;
  logic       err_clr;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       digit_stb;
  logic       err;
  logic [7:0] err_cnt;
  logic       dbg_state;

  // There is no back-pressure on this bus. digit_stb and err are single-cycle pulses.
  // The consumer must sample them on the clock edge that follows their assertion.
  // digit, digit_valid, blank and err_cnt hold their values until the next accept or clear.
  modport master (
    output seg_n, err_clr,
    input  digit, digit_valid, blank, digit_stb, err, err_cnt, dbg_state
  );

  modport slave (
    input  seg_n, err_clr,
    output digit, digit_valid, blank, digit_stb, err, err_cnt, dbg_state
  );
endinterface

// File: rtl/seg7_reader.sv
// Recovers the BCD digit from an active-low 7-segment bus: synchronize, debounce, decode,
// and count illegal patterns.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_reader_if.slave  bus
);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [6:0] r_sync1;
  logic [6:0] r_sync2;
  logic [6:0] r_cand;
  logic [7:0] r_cnt;
  state_t     r_state;
  logic [3:0] r_digit;
  logic       r_digit_valid;
  logic       r_blank;
  logic       r_digit_stb;
  logic       r_err;
  logic [7:0] r_err_cnt;

  logic [6:0] w_p;
  logic       w_accept;
  logic       w_is_digit;
  logic [3:0] w_dec;

  assign w_p      = ~r_sync2;
  // The stable period has ended exactly once when SETTLE sees the counter at its target.
  assign w_accept = (r_state == SETTLE) && (r_cnt == STABLE_N);

  always_comb begin
    w_is_digit = 1'b1;
    w_dec      = 4'd0;
    case (r_cand)
      7'h3F:   w_dec = 4'd0;
      7'h06:   w_dec = 4'd1;
      7'h5B:   w_dec = 4'd2;
      7'h4F:   w_dec = 4'd3;
      7'h66:   w_dec = 4'd4;
      7'h6D:   w_dec = 4'd5;
      7'h7D:   w_dec = 4'd6;
      7'h07:   w_dec = 4'd7;
      7'h7F:   w_dec = 4'd8;
      7'h6F:   w_dec = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1       <= 7'h7F;
      r_sync2       <= 7'h7F;
      r_cand        <= 7'h00;
      r_cnt         <= 8'd0;
      r_state       <= SETTLE;
      r_digit       <= 4'd0;
      r_digit_valid <= 1'b0;
      r_blank       <= 1'b0;
      r_digit_stb   <= 1'b0;
      r_err         <= 1'b0;
      r_err_cnt     <= 8'd0;
    end else begin
      r_sync1     <= bus.seg_n;
      r_sync2     <= r_sync1;
      r_digit_stb <= 1'b0;
      r_err       <= 1'b0;

      if (w_p != r_cand) begin
        r_cand  <= w_p;
        r_cnt   <= 8'd1;
        r_state <= SETTLE;
      end else begin
        if (r_cnt < STABLE_N) begin
          r_cnt <= r_cnt + 8'd1;
        end
        if (w_accept) begin
          r_state <= LOCKED;
        end
      end

      // A pattern that was stable for the full period is still accepted
      // even if the bus moves away on this same edge.
      if (w_accept) begin
        if (w_is_digit) begin
          r_digit       <= w_dec;
          r_digit_valid <= 1'b1;
          r_blank       <= 1'b0;
          r_digit_stb   <= !r_digit_valid || (r_digit != w_dec);
        end else if (r_cand == 7'h00) begin
          r_digit_valid <= 1'b0;
          r_blank       <= 1'b1;
        end else begin
          r_digit_valid <= 1'b0;
          r_blank       <= 1'b0;
          r_err         <= 1'b1;
        end
      end

      if (bus.err_clr) begin
        r_err_cnt <= 8'd0;
      end else if (w_accept && !w_is_digit && (r_cand != 7'h00) && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.digit       = r_digit;
  assign bus.digit_valid = r_digit_valid;
  assign bus.blank       = r_blank;
  assign bus.digit_stb   = r_digit_stb;
  assign bus.err         = r_err;
  assign bus.err_cnt     = r_err_cnt;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: reset/blank, digit decode, glitch rejection, sweep,
// error counting and asynchronous reset.
module tb_seg7_reader;

  logic clk;
  logic rst_n;

  seg7_reader_if bus ();

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run;
  int tests_failed;
  int stb_cnt;
  int err_seen;
  int first_stb;
  logic [3:0] stb_q[$];
  logic [6:0] seg_tab[10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr_counts();
    stb_cnt   = 0;
    err_seen  = 0;
    first_stb = -1;
    stb_q.delete();
  endtask

  // Drives a pattern and observes n edges; edge 0 is the first edge that samples it.
  task automatic hold(input logic [6:0] pat, input int n);
    bus.seg_n = pat;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.digit_stb) begin
        stb_cnt++;
        if (first_stb < 0) first_stb = i;
        stb_q.push_back(bus.digit);
      end
      if (bus.err) err_seen++;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.seg_n   = 7'h7F;
    bus.err_clr = 1'b0;
    #2;
    tests_run++;
    if ({bus.digit, bus.digit_valid, bus.blank, bus.digit_stb, bus.err, bus.err_cnt, bus.dbg_state} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got digit=%0d valid=%0d blank=%0d stb=%0d err=%0d cnt=%0d st=%0d, expected all 0",
               bus.digit, bus.digit_valid, bus.blank, bus.digit_stb, bus.err, bus.err_cnt, bus.dbg_state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_counts();
    hold(7'h7F, 7);
    tests_run++;
    if (bus.blank !== 1'b1 || bus.digit_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_blank: blank=%0d valid=%0d, expected blank=1 valid=0", bus.blank, bus.digit_valid);
    end
    tests_run++;
    if (stb_cnt != 0 || err_seen != 0) begin
      tests_failed++;
      $display("FAIL reset_no_pulse: stb=%0d err=%0d, expected 0 and 0", stb_cnt, err_seen);
    end
  endtask

  task automatic test_single_digit();
    clr_counts();
    hold(7'h30, 12);
    tests_run++;
    if (stb_cnt != 1 || first_stb != 6) begin
      tests_failed++;
      $display("FAIL single_stb: count=%0d edge=%0d, expected count=1 edge=6", stb_cnt, first_stb);
    end
    tests_run++;
    if (bus.digit !== 4'd3 || bus.digit_valid !== 1'b1 || bus.blank !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_digit: digit=%0d valid=%0d blank=%0d, expected 3 1 0", bus.digit, bus.digit_valid, bus.blank);
    end
  endtask

  task automatic test_glitch();
    clr_counts();
    hold(7'h79, 3);
    hold(7'h30, 12);
    tests_run++;
    if (stb_cnt != 0 || err_seen != 0 || bus.digit !== 4'd3 || bus.digit_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_reject: stb=%0d err=%0d digit=%0d valid=%0d, expected 0 0 3 1",
               stb_cnt, err_seen, bus.digit, bus.digit_valid);
    end
    clr_counts();
    hold(7'h79, 8);
    tests_run++;
    if (stb_cnt != 1 || first_stb != 6 || bus.digit !== 4'd1) begin
      tests_failed++;
      $display("FAIL glitch_long: stb=%0d edge=%0d digit=%0d, expected 1 6 1", stb_cnt, first_stb, bus.digit);
    end
  endtask

  task automatic test_sweep();
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    clr_counts();
    for (int d = 0; d < 10; d++) hold(seg_tab[d], 10);
    tests_run++;
    if (stb_cnt != 10) begin
      tests_failed++;
      $display("FAIL sweep_count: strobes=%0d, expected 10", stb_cnt);
    end
    for (int k = 0; k < stb_q.size() && k < 10; k++) begin
      tests_run++;
      if (stb_q[k] !== 4'(k)) begin
        tests_failed++;
        $display("FAIL sweep_digit[%0d]: got %0d, expected %0d", k, stb_q[k], k);
      end
    end
    clr_counts();
    hold(seg_tab[9], 10);
    tests_run++;
    if (stb_cnt != 0 || bus.digit !== 4'd9) begin
      tests_failed++;
      $display("FAIL sweep_repeat: strobes=%0d digit=%0d, expected 0 9", stb_cnt, bus.digit);
    end
  endtask

  task automatic test_errors();
    clr_counts();
    hold(7'h7E, 8);
    tests_run++;
    if (err_seen != 1 || stb_cnt != 0 || bus.err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL err_single: err=%0d stb=%0d cnt=%0d, expected 1 0 1", err_seen, stb_cnt, bus.err_cnt);
    end
    tests_run++;
    if (bus.digit_valid !== 1'b0 || bus.blank !== 1'b0 || bus.digit !== 4'd9) begin
      tests_failed++;
      $display("FAIL err_flags: valid=%0d blank=%0d digit=%0d, expected 0 0 9", bus.digit_valid, bus.blank, bus.digit);
    end
    clr_counts();
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h7D : 7'h7E, 8);
    tests_run++;
    if (err_seen != 300 || bus.err_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL err_saturate: pulses=%0d cnt=%0d, expected 300 255", err_seen, bus.err_cnt);
    end
    // The last toggle left 7E on the bus, so 7D is a new illegal pattern; clear lands on its accept edge.
    clr_counts();
    hold(7'h7D, 6);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL err_clr_wins: err=%0d cnt=%0d, expected 1 0", bus.err, bus.err_cnt);
    end
    bus.err_clr = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL err_after_clr: err=%0d cnt=%0d, expected 0 0", bus.err, bus.err_cnt);
    end
  endtask

  task automatic test_async_reset();
    clr_counts();
    hold(7'h7E, 8);
    hold(7'h30, 10);
    tests_run++;
    if (bus.digit !== 4'd3 || bus.err_cnt !== 8'd1 || bus.dbg_state !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_setup: digit=%0d cnt=%0d st=%0d, expected 3 1 1", bus.digit, bus.err_cnt, bus.dbg_state);
    end
    hold(7'h40, 3);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.digit, bus.digit_valid, bus.blank, bus.digit_stb, bus.err, bus.err_cnt, bus.dbg_state} !== 17'd0) begin
      tests_failed++;
      $display("FAIL areset_clear: digit=%0d valid=%0d blank=%0d stb=%0d err=%0d cnt=%0d st=%0d, expected all 0",
               bus.digit, bus.digit_valid, bus.blank, bus.digit_stb, bus.err, bus.err_cnt, bus.dbg_state);
    end
    bus.seg_n = 7'h7F;
    #3;
    rst_n = 1'b1;
    clr_counts();
    hold(7'h7F, 7);
    tests_run++;
    if (stb_cnt != 0 || err_seen != 0 || bus.blank !== 1'b1 || bus.digit_valid !== 1'b0 || bus.digit !== 4'd0) begin
      tests_failed++;
      $display("FAIL areset_release: stb=%0d err=%0d blank=%0d valid=%0d digit=%0d, expected 0 0 1 0 0",
               stb_cnt, err_seen, bus.blank, bus.digit_valid, bus.digit);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_digit();
    test_glitch();
    test_sweep();
    test_errors();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
